mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: CLK in 1, rising-edge clock; Reset in 1, synchronous active-high reset.
REQ-002 SHALL provide the fetch-side ports: if_req in 1, fetch request; if_addr in 32, fetch address; if_rdata out 32, fetched instruction; if_ready out 1, fetch complete.
REQ-003 SHALL provide the data-side request ports: d_rd_en in 1, load; d_wr_en in 1, store; d_addr in 32; d_wdata in 32; d_type in 3, transfer size (func3 encoding).
REQ-004 SHALL provide the data-side response ports: d_rdata out 32, load data; d_ready out 1, data access complete.
REQ-005 SHALL provide the memory request ports: mem_req out 1; mem_we out 1; mem_addr out 32; mem_wdata out 32; mem_type out 3.
REQ-006 SHALL provide the memory response ports: mem_rdata in 32; mem_ack in 1, access done.
REQ-007 SHALL provide the status ports: cpu_stall out 1, hold all pipeline registers; mem_err out 1, one-cycle timeout pulse.

Function
REQ-008 SHALL share one single-ported memory between instruction fetch and data access, using FSM states IDLE, FETCH, DATA.
REQ-009 IDLE: SHALL arbitrate pending requests; the chosen request is registered into mem_* and the FSM enters FETCH or DATA on the next edge.
REQ-010 Default priority when if_req and d_rd_en|d_wr_en are both high SHALL be data first (older instruction).
REQ-011 d_rd_en and d_wr_en both high SHALL be treated as a store (mem_we=1).
REQ-012 In FETCH/DATA, mem_req=1 with mem_addr, mem_we, mem_wdata and mem_type held stable until the cycle mem_ack=1.
REQ-013 On ack: mem_rdata SHALL be registered into if_rdata or d_rdata, and the matching if_ready or d_ready pulses for exactly one cycle on the following cycle.
REQ-014 Back-to-back: on ack, if the other requester is pending, the FSM SHALL go directly to its state; otherwise it SHALL go to IDLE; mem_req SHALL drop for at least one cycle between accesses.
REQ-015 Minimum access latency SHALL be request to ready = 3 cycles with zero-wait memory (arbitrate, mem cycle with ack, ready).
REQ-016 Requesters hold their request and fields until ready; a request dropped mid-access SHALL still complete, with its ready pulse generated and ignorable.
REQ-017 cpu_stall SHALL equal (if_req & ~if_ready) | ((d_rd_en|d_wr_en) & ~d_ready), combinationally.
REQ-018 Watchdog: an 8-bit counter SHALL count cycles in FETCH/DATA without ack.
REQ-019 At count 255 the watchdog SHALL abort: mem_err pulses 1 cycle, the matching ready pulses with rdata=32'h0000_0013 (NOP), and the FSM goes to IDLE.
REQ-020 mem_ack in IDLE SHALL be ignored.
REQ-021 mem_wdata and mem_type SHALL pass through unmodified; size alignment is owned by the existing memory controller.

Reset
REQ-022 Reset SHALL be sampled on rising CLK only; when asserted, state returns to IDLE on that edge, including mid-access.
REQ-023 After reset: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_type=0, if_ready=0, d_ready=0, if_rdata=0, d_rdata=0, mem_err=0, watchdog=0, RR pointer=data.
REQ-024 An access in flight at reset SHALL be abandoned; a late mem_ack SHALL be ignored.

Configuration
REQ-025 Macro MEM_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-026 With MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, the side not granted last SHALL win; a 1-bit last-grant register updates on each grant.
REQ-027 Without MEM_ARB_ROUND_ROBIN_EN: fixed data priority per REQ-010, and no last-grant register.

Structure
REQ-028 Package mem_arb_pkg SHALL hold the state enum (IDLE/FETCH/DATA), WDOG_MAX=8'd255, NOP_INSTR=32'h0000_0013, and the mem_type encodings (LB/LH/LW/LBU/LHU).
REQ-029 The watchdog SHALL be a sub-module mem_arb_watchdog (clear, enable, expire outputs); all other logic stays in mem_port_arbiter.

Verification
REQ-030 Fetch only, if_addr=0x100, ack next cycle, mem_rdata=0x00500093: mem_addr=0x100 for 1 cycle; if_rdata=0x00500093 and if_ready=1 at cycle 3.
REQ-031 Simultaneous fetch 0x104 and load d_addr=0x2000: DATA served first (both modes on first conflict); FETCH follows with no IDLE; cpu_stall high until both readies are seen.
REQ-032 Store d_addr=0x2004, d_wdata=0xDEADBEEF, d_type=3'b010, ack delayed 4 cycles: mem_we=1 with fields stable for 5 cycles; d_ready is a single pulse.
REQ-033 No ack for 255 cycles in FETCH: mem_err 1-cycle pulse, if_rdata=0x00000013, FSM back in IDLE.
REQ-034 Reset asserted mid-DATA, then late mem_ack: mem_req=0 next edge; no ready pulses.
REQ-035 MEM_ARB_ROUND_ROBIN_EN defined, continuous fetch and data requests: grants alternate F/D/F/D, and neither side waits more than one other access.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned WDOG_W = 8;

    localparam logic [WDOG_W-1:0] WDOG_MAX  = 8'd255;
    localparam logic [XLEN-1:0]   NOP_INSTR = 32'h0000_0013;

    // Transfer size encodings (func3), passed through to the memory controller
    localparam logic [TYPE_W-1:0] MEM_LB  = 3'b000;
    localparam logic [TYPE_W-1:0] MEM_LH  = 3'b001;
    localparam logic [TYPE_W-1:0] MEM_LW  = 3'b010;
    localparam logic [TYPE_W-1:0] MEM_LBU = 3'b100;
    localparam logic [TYPE_W-1:0] MEM_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_e;

    // One memory command as presented on the mem_* port
    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [TYPE_W-1:0] mtype;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Counts cycles an issued access waits for ack; flags expiry at WDOG_MAX.
module mem_arb_watchdog
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    logic [WDOG_W-1:0] count;

    // Wait-cycle counter, restarted whenever no access is outstanding or it is acked
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WDOG_W'(1);
        end
    end

    assign expire_c = enable && !clear && (count == WDOG_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration from IDLE;
// without it, data always wins a simultaneous request.
module mem_port_arbiter
    import mem_arb_pkg::*;
(
    input  logic                CLK,
    input  logic                Reset,
    input  logic                if_req,
    input  logic [XLEN-1:0]     if_addr,
    output logic [XLEN-1:0]     if_rdata,
    output logic                if_ready,
    input  logic                d_rd_en,
    input  logic                d_wr_en,
    input  logic [XLEN-1:0]     d_addr,
    input  logic [XLEN-1:0]     d_wdata,
    input  logic [TYPE_W-1:0]   d_type,
    output logic [XLEN-1:0]     d_rdata,
    output logic                d_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [TYPE_W-1:0]   mem_type,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_ack,
    output logic                cpu_stall,
    output logic                mem_err
);

    arb_state_e        state_q, state_d;
    mem_cmd_t          cmd_q, cmd_d;
    mem_cmd_t          if_cmd_c, d_cmd_c;
    logic              req_d;
    logic [XLEN-1:0]   if_rdata_d, d_rdata_d;
    logic              if_ready_d, d_ready_d, err_d;
    logic              pend_if_c, pend_d_c, busy_c, acked_c;
    logic              data_wins_c, grant_if_c, grant_d_c;
    logic              wd_clear_c, wd_en_c, wd_expire_c;

    // A side whose ready is showing this cycle is finished, not pending
    assign pend_if_c = if_req & ~if_ready;
    assign pend_d_c  = (d_rd_en | d_wr_en) & ~d_ready;
    assign cpu_stall = pend_if_c | pend_d_c;

    assign busy_c  = (state_q != IDLE);
    assign acked_c = busy_c & mem_req & mem_ack;

    assign if_cmd_c = '{we: 1'b0, addr: if_addr, wdata: '0, mtype: MEM_LW};
    assign d_cmd_c  = '{we: d_wr_en, addr: d_addr, wdata: d_wdata, mtype: d_type};

    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign mem_type  = cmd_q.mtype;

    assign wd_en_c    = busy_c & mem_req;
    assign wd_clear_c = ~wd_en_c | mem_ack;

    mem_arb_watchdog u_watchdog (
        .clk      (CLK),
        .rst      (Reset),
        .clear    (wd_clear_c),
        .enable   (wd_en_c),
        .expire_c (wd_expire_c)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic rr_data_first;

    // Last-grant pointer: the side not granted most recently wins the next tie
    always_ff @(posedge CLK) begin
        if (Reset) begin
            rr_data_first <= 1'b1;
        end else if (grant_if_c) begin
            rr_data_first <= 1'b1;
        end else if (grant_d_c) begin
            rr_data_first <= 1'b0;
        end
    end

    assign data_wins_c = ~pend_if_c | rr_data_first;
`else
    assign data_wins_c = 1'b1;
`endif

    // Next-state, command and response logic
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        req_d      = mem_req;
        if_rdata_d = if_rdata;
        d_rdata_d  = d_rdata;
        if_ready_d = 1'b0;
        d_ready_d  = 1'b0;
        err_d      = 1'b0;
        grant_if_c = 1'b0;
        grant_d_c  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pend_d_c && data_wins_c) begin
                    grant_d_c = 1'b1;
                end else if (pend_if_c) begin
                    grant_if_c = 1'b1;
                end
                if (grant_d_c) begin
                    cmd_d   = d_cmd_c;
                    req_d   = 1'b1;
                    state_d = DATA;
                end else if (grant_if_c) begin
                    cmd_d   = if_cmd_c;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH, DATA: begin
                if (!mem_req) begin
                    // Turnaround cycle after a back-to-back handover
                    req_d = 1'b1;
                end else if (acked_c || wd_expire_c) begin
                    req_d   = 1'b0;
                    err_d   = wd_expire_c;
                    state_d = IDLE;
                    if (state_q == FETCH) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = acked_c ? mem_rdata : NOP_INSTR;
                        if (acked_c && pend_d_c) begin
                            grant_d_c = 1'b1;
                            cmd_d     = d_cmd_c;
                            state_d   = DATA;
                        end
                    end else begin
                        d_ready_d = 1'b1;
                        d_rdata_d = acked_c ? mem_rdata : NOP_INSTR;
                        if (acked_c && pend_if_c) begin
                            grant_if_c = 1'b1;
                            cmd_d      = if_cmd_c;
                            state_d    = FETCH;
                        end
                    end
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            mem_req  <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            mem_req  <= req_d;
            if_rdata <= if_rdata_d;
            d_rdata  <= d_rdata_d;
            if_ready <= if_ready_d;
            d_ready  <= d_ready_d;
            mem_err  <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level memory/scoreboard
// model plus directed scenarios with hand-computed cycle counts.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        if_req, d_rd_en, d_wr_en;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [2:0]  d_type;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ready, d_ready, mem_req, mem_we, cpu_stall, mem_err;
    logic [2:0]  mem_type;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory responder configuration (written by stimulus only)
    int          ack_delay = 0;
    bit          force_ack = 1'b0;
    bit          resp_fix  = 1'b0;
    logic [31:0] resp_val  = 32'h0;

    // Observation counters (written by monitor only)
    int cnt_if_rdy = 0, cnt_d_rdy = 0, cnt_err = 0, cnt_req = 0;
    bit grants[$];
    bit last_we = 1'b0;

    logic [2:0] tlist [5] = '{MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    int t_idx = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter dut (
        .CLK(CLK), .Reset(Reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_rd_en(d_rd_en), .d_wr_en(d_wr_en), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_type(d_type), .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_type(mem_type), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .cpu_stall(cpu_stall), .mem_err(mem_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor at negedge: scoreboard checks, then drive the memory response
    initial begin : monitor
        bit          prev_req = 0, prev_ack = 0, prev_exp = 0, rst_seen = 0;
        bit          exp_if = 0, exp_d = 0, exp_err = 0, cur_d = 0, expire;
        logic [31:0] exp_if_data = 0, exp_d_data = 0, p_addr = 0, p_wdata = 0;
        logic [2:0]  p_type = 0;
        logic        p_we = 0;
        int          hi_cnt = 0;
        forever begin
            @(negedge CLK);
            if (rst_seen) begin
                chk1("rst mem_req", mem_req, 1'b0);
                chk1("rst mem_we", mem_we, 1'b0);
                chk("rst mem_addr", mem_addr, 32'h0);
                chk("rst mem_wdata", mem_wdata, 32'h0);
                chk("rst mem_type", 32'(mem_type), 32'h0);
                chk1("rst if_ready", if_ready, 1'b0);
                chk1("rst d_ready", d_ready, 1'b0);
                chk("rst if_rdata", if_rdata, 32'h0);
                chk("rst d_rdata", d_rdata, 32'h0);
                chk1("rst mem_err", mem_err, 1'b0);
            end else begin
                chk1("if_ready", if_ready, exp_if);
                if (exp_if) chk("if_rdata", if_rdata, exp_if_data);
                chk1("d_ready", d_ready, exp_d);
                if (exp_d) chk("d_rdata", d_rdata, exp_d_data);
                chk1("mem_err", mem_err, exp_err);
                if (prev_req && !prev_ack && !prev_exp) begin
                    chk1("mem_req held", mem_req, 1'b1);
                    chk("mem_addr stable", mem_addr, p_addr);
                    chk1("mem_we stable", mem_we, p_we);
                    chk("mem_wdata stable", mem_wdata, p_wdata);
                    chk("mem_type stable", 32'(mem_type), 32'(p_type));
                end else if (prev_req) begin
                    chk1("mem_req gap", mem_req, 1'b0);
                end
            end
            chk1("cpu_stall", cpu_stall,
                 (if_req & ~if_ready) | ((d_rd_en | d_wr_en) & ~d_ready));
            if (if_ready) cnt_if_rdy++;
            if (d_ready)  cnt_d_rdy++;
            if (mem_err)  cnt_err++;
            if (mem_req)  cnt_req++;

            // New access: identify requester and check the command fields
            if (mem_req && !prev_req) begin
                cur_d = mem_we || ((d_rd_en || d_wr_en) && mem_addr == d_addr);
                grants.push_back(cur_d);
                last_we = mem_we;
                if (cur_d) begin
                    chk1("d cmd we", mem_we, d_wr_en);
                    chk("d cmd addr", mem_addr, d_addr);
                    chk("d cmd wdata", mem_wdata, d_wdata);
                    chk("d cmd type", 32'(mem_type), 32'(d_type));
                end else begin
                    chk1("f cmd we", mem_we, 1'b0);
                    chk("f cmd addr", mem_addr, if_addr);
                end
            end

            if (force_ack) begin
                mem_ack = 1'b1;
            end else if (mem_req) begin
                hi_cnt++;
                mem_ack = (hi_cnt == ack_delay + 1);
            end else begin
                hi_cnt  = 0;
                mem_ack = 1'b0;
            end
            mem_rdata = resp_fix ? resp_val : (mem_addr ^ 32'h5A5A_0000);
            expire = mem_req && !mem_ack && (hi_cnt == 256) && !Reset;

            exp_if = 0; exp_d = 0; exp_err = 0;
            if (!Reset && mem_req && (mem_ack || expire)) begin
                if (cur_d) begin
                    exp_d = 1; exp_d_data = mem_ack ? mem_rdata : 32'h0000_0013;
                end else begin
                    exp_if = 1; exp_if_data = mem_ack ? mem_rdata : 32'h0000_0013;
                end
                exp_err = expire;
            end
            prev_req = mem_req && !Reset;
            prev_ack = mem_ack;
            prev_exp = expire;
            p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata; p_type = mem_type;
            rst_seen = Reset;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    // Cycle 1 is the cycle the requests are first presented; returns first ready cycles
    task automatic run(input int budget, input int cont_grants, output int if_cyc, output int d_cyc);
        int cyc = 1;
        if_cyc = 0; d_cyc = 0;
        while ((if_req || d_rd_en || d_wr_en) && cyc < budget) begin
            tick();
            cyc++;
            if (if_ready) begin
                if (if_cyc == 0) if_cyc = cyc;
                if (grants.size() < cont_grants) if_addr = if_addr + 32'd4;
                else if_req = 1'b0;
            end
            if (d_ready) begin
                if (d_cyc == 0) d_cyc = cyc;
                if (grants.size() < cont_grants) begin
                    d_addr = d_addr + 32'd4;
                    t_idx  = (t_idx + 1) % 5;
                    d_type = tlist[t_idx];
                end else begin
                    d_rd_en = 1'b0; d_wr_en = 1'b0;
                end
            end
        end
        n_checks++;
        if (if_req || d_rd_en || d_wr_en) begin
            n_fail++;
            $display("FAIL run timeout: requests still pending after %0d cycles", cyc);
            if_req = 1'b0; d_rd_en = 1'b0; d_wr_en = 1'b0;
        end
        tick();
        tick();
    endtask

    initial begin : stim
        int ic, dc, b_if, b_d, b_err, b_req, g0;
        Reset = 1'b1; if_req = 0; if_addr = 0; d_rd_en = 0; d_wr_en = 0;
        d_addr = 0; d_wdata = 0; d_type = 0;
        tick(); tick();
        Reset = 1'b0;
        chk1("reset mem_req", mem_req, 1'b0);
        chk("reset d_rdata", d_rdata, 32'h0);

        // Fetch only, zero-wait memory
        resp_fix = 1; resp_val = 32'h0050_0093; ack_delay = 0;
        b_req = cnt_req; g0 = grants.size();
        if_req = 1; if_addr = 32'h100;
        run(20, 0, ic, dc);
        chk("fetch latency", 32'(ic), 32'd3);
        chk("fetch rdata", if_rdata, 32'h0050_0093);
        chk("fetch mem_req cycles", 32'(cnt_req - b_req), 32'd1);
        chk1("fetch grant side", grants[g0], 1'b0);
        resp_fix = 0;

        // Simultaneous fetch and load after reset: data first, fetch back-to-back
        do_reset();
        g0 = grants.size();
        if_req = 1; if_addr = 32'h104;
        d_rd_en = 1; d_addr = 32'h2000; d_type = MEM_LW;
        run(30, 0, ic, dc);
        chk("conflict d latency", 32'(dc), 32'd3);
        chk("conflict if latency", 32'(ic), 32'd5);
        chk1("conflict first grant", grants[g0], 1'b1);
        chk1("conflict second grant", grants[g0+1], 1'b0);
        chk("conflict d_rdata", d_rdata, 32'h5A5A_2000);
        chk("conflict if_rdata", if_rdata, 32'h5A5A_0104);

        // Store with ack delayed 4 cycles
        ack_delay = 4; b_req = cnt_req; b_d = cnt_d_rdy;
        d_wr_en = 1; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_type = 3'b010;
        run(30, 0, ic, dc);
        chk("store latency", 32'(dc), 32'd7);
        chk("store mem_req cycles", 32'(cnt_req - b_req), 32'd5);
        chk("store ready pulses", 32'(cnt_d_rdy - b_d), 32'd1);
        chk1("store mem_we", last_we, 1'b1);

        // Load and store both asserted is a store
        ack_delay = 0;
        d_rd_en = 1; d_wr_en = 1; d_addr = 32'h2008; d_wdata = 32'h1234_5678; d_type = MEM_LH;
        run(20, 0, ic, dc);
        chk("rd+wr latency", 32'(dc), 32'd3);
        chk1("rd+wr mem_we", last_we, 1'b1);

        // Watchdog: ack arriving on the last allowed cycle still completes normally
        do_reset();
        ack_delay = 255; b_err = cnt_err;
        if_req = 1; if_addr = 32'h1F0;
        run(400, 0, ic, dc);
        chk("late ack latency", 32'(ic), 32'd258);
        chk("late ack no err", 32'(cnt_err - b_err), 32'd0);
        chk("late ack rdata", if_rdata, 32'h5A5A_01F0);

        // Watchdog: no ack at all aborts with a NOP and an error pulse
        ack_delay = 1000; b_err = cnt_err; b_req = cnt_req;
        if_req = 1; if_addr = 32'h200;
        run(400, 0, ic, dc);
        chk("timeout latency", 32'(ic), 32'd258);
        chk("timeout err pulses", 32'(cnt_err - b_err), 32'd1);
        chk("timeout rdata", if_rdata, 32'h0000_0013);
        chk("timeout mem_req cycles", 32'(cnt_req - b_req), 32'd256);
        ack_delay = 0;
        if_req = 1; if_addr = 32'h204;
        run(20, 0, ic, dc);
        chk("after timeout latency", 32'(ic), 32'd3);

        // Reset in the middle of a data access, then a stray ack
        ack_delay = 1000; b_if = cnt_if_rdy; b_d = cnt_d_rdy;
        d_rd_en = 1; d_addr = 32'h2010; d_type = MEM_LBU;
        tick(); tick(); tick();
        chk1("mid-data mem_req", mem_req, 1'b1);
        Reset = 1; d_rd_en = 0;
        tick();
        Reset = 0;
        chk1("reset mid-data mem_req", mem_req, 1'b0);
        force_ack = 1;
        tick(); tick();
        force_ack = 0;
        tick(); tick();
        chk("reset no d_ready", 32'(cnt_d_rdy - b_d), 32'd0);
        chk("reset no if_ready", 32'(cnt_if_rdy - b_if), 32'd0);
        chk1("stray ack mem_req", mem_req, 1'b0);
        ack_delay = 0;

        // Tie from IDLE after a data grant: policy decides
        d_rd_en = 1; d_addr = 32'h2020; d_type = MEM_LHU;
        run(20, 0, ic, dc);
        g0 = grants.size();
        if_req = 1; if_addr = 32'h300;
        d_rd_en = 1; d_addr = 32'h2030; d_type = MEM_LB;
        run(30, 0, ic, dc);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        chk1("tie grant", grants[g0], 1'b0);
        chk("tie if latency", 32'(ic), 32'd3);
        chk("tie d latency", 32'(dc), 32'd5);
`else
        chk1("tie grant", grants[g0], 1'b1);
        chk("tie if latency", 32'(ic), 32'd5);
        chk("tie d latency", 32'(dc), 32'd3);
`endif

        // Continuous requests from both sides: strict alternation starting with data
        do_reset();
        g0 = grants.size(); t_idx = 0;
        if_req = 1; if_addr = 32'h400;
        d_rd_en = 1; d_addr = 32'h3000; d_type = tlist[0];
        run(200, g0 + 8, ic, dc);
        chk1("stream grant count", grants.size() >= g0 + 8, 1'b1);
        for (int i = g0; i < grants.size(); i++) begin
            chk1("stream alternation", grants[i], ((i - g0) % 2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
